// File: rtl/capsense_pkg.sv
// Shared types and widths for the capacitive-sense pad scan controller.
package capsense_pkg;

  localparam int COUNT_W = 8;
  localparam int DBNC_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    DISCHARGE,
    MEASURE,
    EVAL
  } scan_state_e;

endpackage

// File: rtl/capsense_debounce.sv
// Per-button debouncer: flips the pressed level after DEBOUNCE consecutive
// strobed raw samples that disagree with it, and pulses on each 0->1 flip.
module capsense_debounce
  import capsense_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  input  logic raw_i,
  output logic pressed_o,
  output logic press_event_o
);

  localparam logic [DBNC_W-1:0] DBNC_LAST = DBNC_W'(DEBOUNCE - 1);

  logic [DBNC_W-1:0] dbCnt_q, dbCnt_d;
  logic              pressed_q, pressed_d;
  logic              event_q, event_d;

  always_comb begin
    dbCnt_d   = dbCnt_q;
    pressed_d = pressed_q;
    event_d   = 1'b0;
    if (strobe_i) begin
      if (raw_i == pressed_q) begin
        dbCnt_d = '0;
      end else if (dbCnt_q == DBNC_LAST) begin
        dbCnt_d   = '0;
        pressed_d = ~pressed_q;
        event_d   = ~pressed_q;
      end else begin
        dbCnt_d = dbCnt_q + DBNC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbCnt_q   <= '0;
      pressed_q <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      dbCnt_q   <= dbCnt_d;
      pressed_q <= pressed_d;
      event_q   <= event_d;
    end
  end

  assign pressed_o     = pressed_q;
  assign press_event_o = event_q;

endmodule

// File: rtl/capsense_scan_ctrl.sv
// Sequenced capacitive-pad scanner: discharge all pads, release one, time its rise.
// Define CAPSENSE_BASELINE_TRACK_EN to let idle measurements nudge the baseline.
module capsense_scan_ctrl
  import capsense_pkg::*;
#(
  parameter int N_BTN            = 4,
  parameter int DISCHARGE_CYCLES = 64,
  parameter int MAX_COUNT        = 255,
  parameter int THRESHOLD        = 8,
  parameter int DEBOUNCE         = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic [N_BTN-1:0]   pad_in_i,
  output logic [N_BTN-1:0]   pad_drive_low_o,
  output logic [N_BTN-1:0]   pressed_o,
  output logic [N_BTN-1:0]   press_event_o,
  output logic [N_BTN-1:0]   fault_o,
  output logic               scan_done_o,
  output logic [COUNT_W-1:0] last_count_o
);

  localparam int SEL_W   = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int DISCH_W = $clog2(DISCHARGE_CYCLES + 1);
  localparam logic [COUNT_W-1:0] MAX_CNT   = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W:0]   THRESH_W  = (COUNT_W + 1)'(THRESHOLD);
  localparam logic [DISCH_W-1:0] DISCH_LD  = DISCH_W'(DISCHARGE_CYCLES - 1);
  localparam logic [SEL_W-1:0]   LAST_SEL  = SEL_W'(N_BTN - 1);

  scan_state_e        state_q, state_d;
  logic [N_BTN-1:0]   padMeta_q, padSync_q;
  logic [DISCH_W-1:0] dischCnt_q, dischCnt_d;
  logic [COUNT_W-1:0] riseCnt_q, riseCnt_d;
  logic [SEL_W-1:0]   sel_q;
  logic               calPending_q;
  logic [COUNT_W-1:0] baseline_q [N_BTN];
  logic [N_BTN-1:0]   fault_q;
  logic               scanDone_q;
  logic [COUNT_W-1:0] lastCount_q;

  logic               isFault;
  logic               measDone;
  logic [COUNT_W:0]   limit;
  logic               raw;
  logic               evalStrobe;

  assign isFault    = (riseCnt_q == MAX_CNT);
  assign measDone   = padSync_q[sel_q] || isFault;
  assign limit      = {1'b0, baseline_q[sel_q]} + THRESH_W;
  assign raw        = !isFault && ({1'b0, riseCnt_q} > limit);
  assign evalStrobe = (state_q == EVAL) && !calPending_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dischCnt_d = dischCnt_q;
    riseCnt_d  = riseCnt_q;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d    = DISCHARGE;
          dischCnt_d = DISCH_LD;
        end
      end
      DISCHARGE: begin
        if (dischCnt_q == '0) begin
          state_d   = MEASURE;
          riseCnt_d = '0;
        end else begin
          dischCnt_d = dischCnt_q - DISCH_W'(1);
        end
      end
      MEASURE: begin
        // Saturate at MAX_COUNT: a stuck-low pad exits here instead of wrapping.
        if (measDone) begin
          state_d = EVAL;
        end else begin
          riseCnt_d = riseCnt_q + COUNT_W'(1);
        end
      end
      EVAL: begin
        if (enable_i) begin
          state_d    = DISCHARGE;
          dischCnt_d = DISCH_LD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pad_drive_low_o = '1;
    if (state_q == MEASURE) begin
      pad_drive_low_o[sel_q] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      padMeta_q    <= '0;
      padSync_q    <= '0;
      dischCnt_q   <= '0;
      riseCnt_q    <= '0;
      sel_q        <= '0;
      calPending_q <= 1'b1;
      fault_q      <= '0;
      scanDone_q   <= 1'b0;
      lastCount_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        baseline_q[i] <= '0;
      end
    end else begin
      padMeta_q  <= pad_in_i;
      padSync_q  <= padMeta_q;
      dischCnt_q <= dischCnt_d;
      riseCnt_q  <= riseCnt_d;
      scanDone_q <= 1'b0;
      if (state_q == EVAL) begin
        lastCount_q    <= riseCnt_q;
        fault_q[sel_q] <= isFault;
        // The first sweep after reset only learns each pad's idle rise time.
        if (calPending_q) begin
          baseline_q[sel_q] <= riseCnt_q;
        end
`ifdef CAPSENSE_BASELINE_TRACK_EN
        else if (!raw && !isFault) begin
          if (riseCnt_q > baseline_q[sel_q]) begin
            baseline_q[sel_q] <= baseline_q[sel_q] + COUNT_W'(1);
          end else if (riseCnt_q < baseline_q[sel_q]) begin
            baseline_q[sel_q] <= baseline_q[sel_q] - COUNT_W'(1);
          end
        end
`endif
        if (sel_q == LAST_SEL) begin
          sel_q        <= '0;
          scanDone_q   <= 1'b1;
          calPending_q <= 1'b0;
        end else begin
          sel_q <= sel_q + SEL_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_dbnc
    capsense_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .strobe_i     (evalStrobe && (sel_q == SEL_W'(g))),
      .raw_i        (raw),
      .pressed_o    (pressed_o[g]),
      .press_event_o(press_event_o[g])
    );
  end

  assign fault_o      = fault_q;
  assign scan_done_o  = scanDone_q;
  assign last_count_o = lastCount_q;

endmodule

// File: tb/tb_capsense_scan_ctrl.sv
// Self-checking bench for capsense_scan_ctrl: pad rise-time model, slot-level
// reference model compared every cycle, plus directed literal expectations.
module tb_capsense_scan_ctrl;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int MAXC = 255;
  localparam int THR  = 8;
  localparam int DB   = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] padIn = '0;
  logic [N-1:0] padDriveLow;
  logic [N-1:0] pressed;
  logic [N-1:0] pressEvent;
  logic [N-1:0] fault;
  logic         scanDone;
  logic [7:0]   lastCount;

  int testsRun    = 0;
  int testsFailed = 0;

  capsense_scan_ctrl #(
    .N_BTN           (N),
    .DISCHARGE_CYCLES(D),
    .MAX_COUNT       (MAXC),
    .THRESHOLD       (THR),
    .DEBOUNCE        (DB)
  ) dut (
    .clk_i          (clock),
    .rst_i          (reset),
    .enable_i       (enable),
    .pad_in_i       (padIn),
    .pad_drive_low_o(padDriveLow),
    .pressed_o      (pressed),
    .press_event_o  (pressEvent),
    .fault_o        (fault),
    .scan_done_o    (scanDone),
    .last_count_o   (lastCount)
  );

  always #5 clock = ~clock;

  // Pad model: a released pad reads high from K cycles after its release.
  int kCycles [N];
  int relCnt  [N];

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (padDriveLow[i] !== 1'b0) begin
        relCnt[i] = 0;
        padIn[i]  = 1'b0;
      end else begin
        relCnt[i] = relCnt[i] + 1;
        padIn[i]  = (relCnt[i] > kCycles[i]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting, actual none required event at %0t", name, $time);
  endtask

  // Slot-level reference model: each slot is D discharge cycles, count+1
  // measure cycles and one evaluation cycle, results visible the cycle after.
  bit           mRunning, mCal, mScanDone;
  int           mPos, mLen, mCnt, mSel, mLast;
  int           mBase [N];
  int           mDb   [N];
  logic [N-1:0] mPressed, mEvent, mFault;

  task automatic evalSlot();
    bit raw, f;
    mLast        = mCnt;
    f            = (mCnt == MAXC);
    mFault[mSel] = f;
    if (mCal) begin
      mBase[mSel] = mCnt;
    end else begin
      raw = !f && (mCnt > mBase[mSel] + THR);
      if (raw == mPressed[mSel]) begin
        mDb[mSel] = 0;
      end else begin
        mDb[mSel] = mDb[mSel] + 1;
        if (mDb[mSel] == DB) begin
          mDb[mSel]      = 0;
          mPressed[mSel] = ~mPressed[mSel];
          mEvent[mSel]   = mPressed[mSel];
        end
      end
`ifdef CAPSENSE_BASELINE_TRACK_EN
      if (!raw && !f) begin
        if (mCnt > mBase[mSel]) mBase[mSel] = mBase[mSel] + 1;
        else if (mCnt < mBase[mSel]) mBase[mSel] = mBase[mSel] - 1;
      end
`endif
    end
    if (mSel == N - 1) begin
      mScanDone = 1'b1;
      mSel      = 0;
      mCal      = 1'b0;
    end else begin
      mSel = mSel + 1;
    end
  endtask

  task automatic stepModel();
    if (reset) begin
      mRunning  = 1'b0;
      mCal      = 1'b1;
      mScanDone = 1'b0;
      mPos      = 0;
      mLen      = 0;
      mCnt      = 0;
      mSel      = 0;
      mLast     = 0;
      mPressed  = '0;
      mEvent    = '0;
      mFault    = '0;
      for (int i = 0; i < N; i++) begin
        mBase[i] = 0;
        mDb[i]   = 0;
      end
      return;
    end
    mEvent    = '0;
    mScanDone = 1'b0;
    if (mRunning) begin
      mPos = mPos + 1;
      if (mPos == D) begin
        mCnt = (kCycles[mSel] + 2 > MAXC) ? MAXC : kCycles[mSel] + 2;
        mLen = D + mCnt + 2;
      end
      if (mLen != 0 && mPos == mLen) begin
        evalSlot();
        mRunning = 1'b0;
      end
    end
    if (!mRunning && enable) begin
      mRunning = 1'b1;
      mPos     = 0;
      mLen     = 0;
    end
  endtask

  task automatic compareAll();
    logic [N-1:0] expDrive;
    expDrive = '1;
    if (mRunning && mLen != 0 && mPos >= D && mPos <= D + mCnt) begin
      expDrive[mSel] = 1'b0;
    end
    checkOutput("pad_drive_low", 32'(padDriveLow), 32'(expDrive));
    checkOutput("pressed",       32'(pressed),     32'(mPressed));
    checkOutput("press_event",   32'(pressEvent),  32'(mEvent));
    checkOutput("fault",         32'(fault),       32'(mFault));
    checkOutput("scan_done",     32'(scanDone),    32'(mScanDone));
    checkOutput("last_count",    32'(lastCount),   32'(mLast));
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      stepModel();
      compareAll();
    end
  end

  int eventCnt1 = 0;
  bit sawMax    = 1'b0;

  always @(posedge clock) begin
    #1;
    if (pressEvent[1] === 1'b1) eventCnt1++;
    if (lastCount === 8'd255) sawMax = 1'b1;
  end

  task automatic applyStimulus(input int k0, input int k1, input int k2, input int k3);
    kCycles[0] = k0;
    kCycles[1] = k1;
    kCycles[2] = k2;
    kCycles[3] = k3;
  endtask

  task automatic setEnable(input logic v);
    @(negedge clock);
    enable = v;
  endtask

  task automatic waitScanDone(output int cycles);
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (scanDone !== 1'b1 && cycles < 1000);
    if (scanDone !== 1'b1) timeoutFail("scan_done_wait");
  endtask

  task automatic waitSweeps(input int n);
    int c;
    for (int i = 0; i < n; i++) waitScanDone(c);
  endtask

  task automatic waitDrive(input logic [N-1:0] v, input string name);
    int c;
    c = 0;
    do begin
      @(posedge clock);
      #1;
      c++;
    end while (padDriveLow !== v && c < 1000);
    if (padDriveLow !== v) timeoutFail(name);
  endtask

  initial begin
    int cyc;
    reset  = 1'b1;
    enable = 1'b0;
    applyStimulus(20, 20, 20, 20);
    for (int i = 0; i < N; i++) relCnt[i] = 0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_drive",     32'(padDriveLow), 32'hF);
    checkOutput("reset_pressed",   32'(pressed),     32'h0);
    checkOutput("reset_lastcount", 32'(lastCount),   32'h0);
    checkOutput("reset_scandone",  32'(scanDone),    32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("idle_drive", 32'(padDriveLow), 32'hF);

    // Calibration sweep, then a full quiet sweep of 4 x 28 cycles.
    setEnable(1'b1);
    waitScanDone(cyc);
    checkOutput("cal_pressed",   32'(pressed),   32'h0);
    checkOutput("cal_lastcount", 32'(lastCount), 32'd22);
    waitScanDone(cyc);
    checkOutput("sweep_period", 32'(cyc), 32'd112);

    // Sustained touch on button 1 for three sweeps, then release.
    applyStimulus(20, 40, 20, 20);
    waitSweeps(2);
    checkOutput("press_early", 32'(pressed), 32'h0);
    waitSweeps(1);
    checkOutput("press_level", 32'(pressed), 32'h2);
    checkOutput("press_events", 32'(eventCnt1), 32'd1);
    applyStimulus(20, 20, 20, 20);
    waitSweeps(2);
    checkOutput("release_early", 32'(pressed), 32'h2);
    waitSweeps(1);
    checkOutput("release_level", 32'(pressed), 32'h0);

    // Single-sweep glitch must be rejected.
    applyStimulus(20, 40, 20, 20);
    waitSweeps(1);
    applyStimulus(20, 20, 20, 20);
    waitSweeps(3);
    checkOutput("glitch_pressed", 32'(pressed), 32'h0);
    checkOutput("glitch_events",  32'(eventCnt1), 32'd1);

    // Pad 2 stuck low: saturates, faults, never presses; others keep going.
    sawMax = 1'b0;
    applyStimulus(20, 20, 1000, 20);
    waitSweeps(1);
    checkOutput("fault_flag",     32'(fault),     32'h4);
    checkOutput("fault_pressed",  32'(pressed),   32'h0);
    checkOutput("fault_saw_max",  32'(sawMax),    32'h1);
    checkOutput("fault_lastcount", 32'(lastCount), 32'd22);
    applyStimulus(20, 20, 20, 20);
    waitSweeps(1);
    checkOutput("fault_clear", 32'(fault), 32'h0);

    // Drop enable while button 3 is measuring; slot completes, then idle.
    waitDrive(4'b0111, "wait_btn3_measure");
    setEnable(1'b0);
    waitScanDone(cyc);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("disable_drive", 32'(padDriveLow), 32'hF);
    setEnable(1'b1);
    waitDrive(4'b1110, "resume_btn0");
    checkOutput("resume_drive", 32'(padDriveLow), 32'hE);

    // Reset in the middle of button 1's measurement, then recalibrate.
    waitDrive(4'b1101, "wait_btn1_measure");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midreset_drive",   32'(padDriveLow), 32'hF);
    checkOutput("midreset_pressed", 32'(pressed),     32'h0);
    @(negedge clock);
    reset = 1'b0;
    waitSweeps(2);
    checkOutput("recal_pressed",   32'(pressed),   32'h0);
    checkOutput("recal_lastcount", 32'(lastCount), 32'd22);

    repeat (4) @(posedge clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
